// File: rtl/mbist_march_engine.sv
// March C- / MATS+ memory BIST engine with a spare-row remap table for built-in repair.
// One memory op per enabled cycle; read data is compared one cycle after each read.
module mbist_march_engine #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int NUM_SPARE = 4,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = (NUM_SPARE > 1) ? $clog2(NUM_SPARE) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic              repair_ok_o,
  output logic [CNT_W-1:0]  fail_count_o,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic [IDX_W-1:0]  lookup_idx_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q;
  logic                mode_q;
  logic [2:0]          elem_q, elem_d;
  logic                opIdx_q, opIdx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                memEn_q, memWe_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic                busy_q, done_q, fail_q, repairOk_q;
  logic [CNT_W-1:0]    failCount_q;
  logic                drainCnt_q;
  logic                cmpPending_q, cmpExpBit_q;
  logic [ADDR_W-1:0]   cmpAddr_q;
  logic                holdValid_q;
  logic [DATA_W-1:0]   hold_q;
  logic [NUM_SPARE-1:0] tblValid_q;
  logic [ADDR_W-1:0]   tblAddr_q [NUM_SPARE];

  // Elements: March C- e0..e5, MATS+ e0..e2; e0 is the w0 sweep, two-op elements read then write.
  function automatic logic elemDown(input logic m, input logic [2:0] e);
    return m ? (e == 3'd2) : (e == 3'd3 || e == 3'd4);
  endfunction

  function automatic logic elemTwo(input logic m, input logic [2:0] e);
    return (e != 3'd0) && !(!m && e == 3'd5);
  endfunction

  function automatic logic opIsRead(input logic m, input logic [2:0] e, input logic o);
    return elemTwo(m, e) ? !o : (e != 3'd0);
  endfunction

  logic twoOps, goDown, addrEnd, lastOfAddr, lastOp;
  logic [2:0] lastElem;

  always_comb begin
    twoOps     = elemTwo(mode_q, elem_q);
    goDown     = elemDown(mode_q, elem_q);
    lastElem   = mode_q ? 3'd2 : 3'd5;
    addrEnd    = goDown ? (addr_q == '0) : (addr_q == '1);
    lastOfAddr = !twoOps || opIdx_q;
    lastOp     = lastOfAddr && addrEnd && (elem_q == lastElem);
    elem_d     = elem_q;
    addr_d     = addr_q;
    opIdx_d    = 1'b0;
    if (!lastOfAddr) begin
      opIdx_d = 1'b1;
    end else if (!addrEnd) begin
      addr_d = goDown ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end else begin
      elem_d = elem_q + 3'd1;
      addr_d = elemDown(mode_q, elem_d) ? '1 : '0;
    end
  end

  // A read datum captured during a freeze is compared instead of the live bus.
  logic [DATA_W-1:0] cmpData;
  logic              miscompare;
  logic              tblHit, freeFound;
  logic [IDX_W-1:0]  freeIdx;

  always_comb begin
    cmpData    = holdValid_q ? hold_q : mem_rdata_i;
    miscompare = cmpPending_q && (cmpData != {DATA_W{cmpExpBit_q}});
    tblHit     = 1'b0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    for (int i = 0; i < NUM_SPARE; i++) begin
      if (tblValid_q[i] && tblAddr_q[i] == cmpAddr_q) tblHit = 1'b1;
      if (!tblValid_q[i] && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

  // Scanning downwards lets the lowest matching entry win.
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    for (int i = NUM_SPARE - 1; i >= 0; i--) begin
      if (tblValid_q[i] && tblAddr_q[i] == lookup_addr_i) begin
        lookup_hit_o = 1'b1;
        lookup_idx_o = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      elem_q       <= '0;
      opIdx_q      <= 1'b0;
      addr_q       <= '0;
      memEn_q      <= 1'b0;
      memWe_q      <= 1'b0;
      memWdata_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      repairOk_q   <= 1'b1;
      failCount_q  <= '0;
      drainCnt_q   <= 1'b0;
      cmpPending_q <= 1'b0;
      cmpExpBit_q  <= 1'b0;
      cmpAddr_q    <= '0;
      holdValid_q  <= 1'b0;
      hold_q       <= '0;
      tblValid_q   <= '0;
      for (int i = 0; i < NUM_SPARE; i++) tblAddr_q[i] <= '0;
    end else if (ena_i) begin
      holdValid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_RUN;
            mode_q       <= mode_i;
            elem_q       <= '0;
            opIdx_q      <= 1'b0;
            addr_q       <= '0;
            memEn_q      <= 1'b1;
            memWe_q      <= 1'b1;
            memWdata_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            repairOk_q   <= 1'b1;
            failCount_q  <= '0;
            cmpPending_q <= 1'b0;
            tblValid_q   <= '0;
          end
        end
        S_RUN, S_DRAIN: begin
          if (miscompare) begin
            fail_q <= 1'b1;
            if (failCount_q != {CNT_W{1'b1}}) failCount_q <= failCount_q + CNT_W'(1);
            if (!tblHit) begin
              if (freeFound) begin
                tblValid_q[freeIdx] <= 1'b1;
                tblAddr_q[freeIdx]  <= cmpAddr_q;
              end else begin
                repairOk_q <= 1'b0;
              end
            end
          end
          cmpPending_q <= memEn_q && !memWe_q;
          cmpExpBit_q  <= ~elem_q[0];
          cmpAddr_q    <= addr_q;
          if (state_q == S_RUN) begin
            if (lastOp) begin
              state_q    <= S_DRAIN;
              memEn_q    <= 1'b0;
              memWe_q    <= 1'b0;
              drainCnt_q <= 1'b0;
            end else begin
              elem_q     <= elem_d;
              addr_q     <= addr_d;
              opIdx_q    <= opIdx_d;
              memWe_q    <= !opIsRead(mode_q, elem_d, opIdx_d);
              memWdata_q <= {DATA_W{elem_d[0]}};
            end
          end else begin
            drainCnt_q <= 1'b1;
            if (drainCnt_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end else if (cmpPending_q && !holdValid_q) begin
      hold_q      <= mem_rdata_i;
      holdValid_q <= 1'b1;
    end
  end

  assign mem_en_o     = memEn_q && ena_i;
  assign mem_we_o     = memWe_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = memWdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign repair_ok_o  = repairOk_q;
  assign fail_count_o = failCount_q;

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: faulty SRAM model, spec-level March reference model,
// directed and randomised runs with freezes, mid-run start pulses and resets.
module tb_mbist_march_engine;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int CW = 8;
  localparam int IW = 2;
  localparam int DEPTH = 1 << AW;

  // Op codes per element slot: 0=w0 1=w1 2=r0 3=r1 -1=none
  localparam int MARCH_C_OPS [12] = '{0, -1, 2, 1, 3, 0, 2, 1, 3, 0, 2, -1};
  localparam int MARCH_C_DOWN [6] = '{0, 0, 0, 1, 1, 0};
  localparam int MATS_OPS [6] = '{0, -1, 2, 1, 3, 0};
  localparam int MATS_DOWN [3] = '{0, 0, 1};

  logic          clk = 1'b0;
  logic          rstN, ena, start, mode;
  logic          memEn, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata = '0;
  logic          busy, done, fail, repairOk;
  logic [CW-1:0] failCount;
  logic [AW-1:0] lookupAddr;
  logic          lookupHit;
  logic [IW-1:0] lookupIdx;

  logic [DW-1:0] memArr [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];
  logic [31:0]   traceQ [$];
  logic [31:0]   expTrace [$];
  int            expTable [$];
  int            expCount;
  bit            expRepairOk;
  bit            enDuringFreeze = 1'b0;
  int            total = 0;
  int            bad = 0;

  mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_SPARE(NS), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rstN), .ena_i(ena), .start_i(start), .mode_i(mode),
    .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata), .busy_o(busy), .done_o(done), .fail_o(fail),
    .repair_ok_o(repairOk), .fail_count_o(failCount), .lookup_addr_i(lookupAddr),
    .lookup_hit_o(lookupHit), .lookup_idx_o(lookupIdx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] packOp(input bit we, input int a, input logic [DW-1:0] d);
    return 32'({we, AW'(a), d});
  endfunction

  // SRAM with stuck-at cells; read data is only meaningful the cycle after a read.
  always @(posedge clk) begin
    if (memEn && !memWe) begin
      memRdata <= memArr[memAddr];
    end else begin
      memRdata <= DW'($urandom);
    end
    if (memEn) begin
      traceQ.push_back(packOp(memWe, int'(memAddr), memWe ? memWdata : '0));
      if (memWe) memArr[memAddr] <= (memWdata | sa1[memAddr]) & ~sa0[memAddr];
    end
    if (!ena && memEn) enDuringFreeze <= 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearFaults();
    for (int a = 0; a < DEPTH; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endtask

  // Walks the algorithm over an abstract faulty memory and logs failures.
  task automatic modelRun(input bit m);
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] val;
    int nEl, a, op;
    bit down, found;
    expTrace.delete();
    expTable.delete();
    expCount = 0;
    expRepairOk = 1'b1;
    nEl = m ? 3 : 6;
    for (int e = 0; e < nEl; e++) begin
      down = m ? (MATS_DOWN[e] != 0) : (MARCH_C_DOWN[e] != 0);
      for (int i = 0; i < DEPTH; i++) begin
        a = down ? DEPTH - 1 - i : i;
        for (int k = 0; k < 2; k++) begin
          op = m ? MATS_OPS[2*e+k] : MARCH_C_OPS[2*e+k];
          if (op < 0) continue;
          val = (op == 1 || op == 3) ? '1 : '0;
          if (op < 2) begin
            mm[a] = (val | sa1[a]) & ~sa0[a];
            expTrace.push_back(packOp(1'b1, a, val));
          end else begin
            expTrace.push_back(packOp(1'b0, a, '0));
            if (mm[a] !== val) begin
              if (expCount < (1 << CW) - 1) expCount++;
              found = 1'b0;
              foreach (expTable[j]) if (expTable[j] == a) found = 1'b1;
              if (!found) begin
                if (expTable.size() < NS) expTable.push_back(a);
                else expRepairOk = 1'b0;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit m, input int dropAt, input int dropLen,
                               input int startAt, input int rstAt, output int cycles);
    @(negedge clk);
    traceQ.delete();
    mode = m;
    start = 1'b1;
    ena = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("acceptBusy", busy, 1);
    checkOutput("acceptDoneClr", done, 0);
    checkOutput("acceptFailClr", fail, 0);
    checkOutput("acceptCntClr", failCount, 0);
    checkOutput("acceptRepairOk", repairOk, 1);
    checkOutput("firstOpEn", memEn, 1);
    checkOutput("firstOpWe", memWe, 1);
    checkOutput("firstOpAddr", memAddr, 0);
    cycles = 0;
    while (cycles < 1000) begin
      @(negedge clk);
      start = (cycles == startAt);
      ena = !(cycles >= dropAt && cycles < dropAt + dropLen);
      if (cycles == rstAt) rstN = 1'b0;
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == rstAt + 1) begin
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstFail", fail, 0);
        checkOutput("rstCount", failCount, 0);
        checkOutput("rstRepairOk", repairOk, 1);
        checkOutput("rstMemEn", memEn, 0);
        checkOutput("rstMemWe", memWe, 0);
        checkOutput("rstMemAddr", memAddr, 0);
        checkOutput("rstWdata", memWdata, 0);
        checkOutput("rstLookupHit", lookupHit, 0);
        @(negedge clk);
        rstN = 1'b1;
        start = 1'b0;
        ena = 1'b1;
        traceQ.delete();
        return;
      end
      if (done) break;
    end
    if (!done) checkOutput("doneTimeout", done, 1);
    @(negedge clk);
    start = 1'b0;
    ena = 1'b1;
  endtask

  task automatic checkResults();
    int traceBad = 0;
    int n;
    bit hitExp;
    int idxExp;
    checkOutput("busyLow", busy, 0);
    checkOutput("doneHigh", done, 1);
    checkOutput("failFlag", fail, 32'(expCount != 0));
    checkOutput("failCount", failCount, expCount);
    checkOutput("repairOk", repairOk, 32'(expRepairOk));
    checkOutput("traceLen", traceQ.size(), expTrace.size());
    n = (traceQ.size() < expTrace.size()) ? traceQ.size() : expTrace.size();
    for (int i = 0; i < n; i++) if (traceQ[i] !== expTrace[i]) traceBad++;
    checkOutput("traceOps", traceBad, 0);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      lookupAddr = AW'(a);
      hitExp = 1'b0;
      idxExp = 0;
      foreach (expTable[j]) begin
        if (expTable[j] == a && !hitExp) begin
          hitExp = 1'b1;
          idxExp = j;
        end
      end
      #1;
      checkOutput("lookupHit", lookupHit, 32'(hitExp));
      checkOutput("lookupIdx", lookupIdx, idxExp);
    end
  endtask

  initial begin
    int cycles, nFaults, a, b;
    bit m;
    int dropAt, dropLen;
    rstN = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    lookupAddr = '0;
    clearFaults();
    for (int i = 0; i < DEPTH; i++) memArr[i] = DW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetFail", fail, 0);
    checkOutput("resetRepairOk", repairOk, 1);
    checkOutput("resetCount", failCount, 0);
    checkOutput("resetMemEn", memEn, 0);
    checkOutput("resetLookupHit", lookupHit, 0);
    @(negedge clk);
    rstN = 1'b1;

    // Start while frozen must not be taken.
    @(negedge clk);
    start = 1'b1;
    ena = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("startFrozenBusy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    ena = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("startFrozenIdle", busy, 0);

    // Fault-free March C- and MATS+.
    modelRun(1'b0);
    applyStimulus(1'b0, 100000, 0, -1, -1, cycles);
    checkOutput("marchCCycles", cycles, 10 * DEPTH + 2);
    checkResults();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("doneSticky", done, 1);

    modelRun(1'b1);
    applyStimulus(1'b1, 100000, 0, -1, -1, cycles);
    checkOutput("matsCycles", cycles, 5 * DEPTH + 2);
    checkResults();

    // Single stuck-at-1 bit: three r0 misses at one address.
    clearFaults();
    sa1[5] = 8'h08;
    modelRun(1'b0);
    applyStimulus(1'b0, 100000, 0, -1, -1, cycles);
    checkOutput("sa1Count", failCount, 3);
    checkResults();

    // Five faulty rows overflow a four-entry table.
    clearFaults();
    foreach (sa0[i]) if (i inside {1, 2, 3, 4, 9}) sa0[i] = DW'(1) << $urandom_range(DW - 1, 0);
    modelRun(1'b0);
    applyStimulus(1'b0, 100000, 0, -1, -1, cycles);
    checkOutput("overflowRepair", repairOk, 0);
    checkResults();

    // Freeze for seven cycles and a start pulse during the run.
    clearFaults();
    enDuringFreeze = 1'b0;
    modelRun(1'b0);
    applyStimulus(1'b0, 50, 7, 60, -1, cycles);
    checkOutput("freezeCycles", cycles, 10 * DEPTH + 2 + 7);
    checkResults();

    // Randomised faults, mode, freeze point and stray start.
    for (int it = 0; it < 8; it++) begin
      clearFaults();
      nFaults = $urandom_range(6, 0);
      for (int f = 0; f < nFaults; f++) begin
        a = $urandom_range(DEPTH - 1, 0);
        b = $urandom_range(DW - 1, 0);
        if ($urandom_range(1, 0) != 0) sa1[a] |= DW'(1) << b;
        else sa0[a] |= DW'(1) << b;
      end
      m = 1'($urandom_range(1, 0));
      dropAt = $urandom_range(60, 1);
      dropLen = $urandom_range(9, 1);
      modelRun(m);
      applyStimulus(m, dropAt, dropLen, $urandom_range(70, 1), -1, cycles);
      checkOutput("randCycles", cycles, (m ? 5 : 10) * DEPTH + 2 + dropLen);
      checkResults();
    end
    checkOutput("memEnFrozen", 32'(enDuringFreeze), 0);

    // Reset mid-run after a failure has been logged, then a clean rerun.
    clearFaults();
    sa1[5] = 8'h08;
    @(negedge clk);
    lookupAddr = AW'(5);
    applyStimulus(1'b0, 100000, 0, -1, 40, cycles);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("noAccessAfterRst", traceQ.size(), 0);
    checkOutput("idleAfterRst", busy, 0);
    modelRun(1'b0);
    applyStimulus(1'b0, 100000, 0, -1, -1, cycles);
    checkOutput("rerunCycles", cycles, 10 * DEPTH + 2);
    checkResults();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
